// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state/parity encodings and bit-period helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  function automatic logic [18:0] bit_period(input logic [15:0] p);
    return {(p == 16'd0) ? 16'd1 : p, 3'b000} - 19'd1;
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period down-counter that ticks at zero and reloads
module uart_baud_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [18:0] period,
  output logic        tick
);
  logic [18:0] cnt;
  assign tick = en && cnt == 19'd0;
  // load at frame start, reload on every tick, otherwise count down while a frame runs
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load || tick) cnt <= period;
    else if (en) cnt <= cnt - 19'd1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: AXI-stream fed UART transmitter with optional parity and 1/2 stop bits
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  txd,
  output logic                  busy,
  input  logic [15:0]           prescale,
  input  logic [1:0]            parity_mode,
  input  logic                  stop_bits
);
  import uart_pkg::*;
  localparam logic [3:0] LAST = 4'(DATA_WIDTH - 1);
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] sh, sh_n;
  logic [3:0] bit_cnt, cnt_n;
  logic [15:0] p_q;
  logic armed, stop2, par_en, par, txd_n, tick, xfer;
  assign s_axis_tready = armed && state == IDLE;
  assign busy = state != IDLE;
  assign xfer = s_axis_tvalid && s_axis_tready;
  uart_baud_gen u_baud (
    .clk(clk),
    .rst(rst),
    .en(busy),
    .load(xfer),
    .period(bit_period(xfer ? prescale : p_q)),
    .tick(tick)
  );
  // state, datapath and frame settings captured on each accepted word
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      sh      <= '0;
      bit_cnt <= '0;
      txd     <= 1'b1;
      armed   <= 1'b0;
      p_q     <= '0;
      stop2   <= 1'b0;
      par_en  <= 1'b0;
      par     <= 1'b0;
    end else begin
      state   <= state_n;
      sh      <= sh_n;
      bit_cnt <= cnt_n;
      txd     <= txd_n;
      armed   <= 1'b1;
      if (xfer) begin
        p_q    <= prescale;
        stop2  <= stop_bits;
        par_en <= parity_mode == PAR_EVEN || parity_mode == PAR_ODD;
        par    <= ^s_axis_tdata ^ (parity_mode == PAR_ODD);
      end
    end
  // next state, shifter and bit counter; txd is the line level of the next state
  always_comb begin
    state_n = state;
    sh_n    = sh;
    cnt_n   = bit_cnt;
    unique case (state)
      IDLE: if (xfer) begin
        state_n = START;
        sh_n    = s_axis_tdata;
      end
      START: if (tick) begin
        state_n = DATA;
        cnt_n   = '0;
      end
      DATA: if (tick) begin
        sh_n  = sh >> 1;
        cnt_n = bit_cnt + 4'd1;
        if (bit_cnt == LAST) begin
          state_n = par_en ? PARITY : STOP;
          cnt_n   = '0;
        end
      end
      PARITY: if (tick) state_n = STOP;
      STOP: if (tick) begin
        cnt_n = bit_cnt + 4'd1;
        if (bit_cnt == {3'b000, stop2}) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
    txd_n = state_n == START  ? 1'b0 :
            state_n == DATA   ? sh_n[0] :
            state_n == PARITY ? par : 1'b1;
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx
module tb_uart_tx;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] tdata = '0;
  logic tvalid = 1'b0, tready, txd, busy, stop_bits = 1'b0;
  logic [15:0] prescale = 16'd1;
  logic [1:0] parity_mode = 2'b00;
  logic line [0:4095];
  int n_tests = 0, n_fail = 0;
  int n, n2, run;

  uart_tx dut (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready), .txd(txd), .busy(busy), .prescale(prescale),
    .parity_mode(parity_mode), .stop_bits(stop_bits)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_frame(input logic [7:0] d, input logic [15:0] p,
                             input logic [1:0] pm, input logic st, input logic keep);
    int w = 0;
    tdata = d; prescale = p; parity_mode = pm; stop_bits = st; tvalid = 1'b1;
    while (!tready && w < 4000) begin
      @(posedge clk); #1; w++;
    end
    check("accept_wait", int'(tready), 1);
    @(posedge clk); #1;
    tvalid = keep;
  endtask

  task automatic capture(output int len);
    len = 0;
    while (!tready && len < 4000) begin
      line[len] = txd;
      len++;
      @(posedge clk); #1;
    end
  endtask

  task automatic check_frame(input string nm, input logic [7:0] d, input int p,
                             input logic [1:0] pm, input logic st, input int len);
    logic b [0:11];
    int nb = 0;
    int bp = 8 * (p == 0 ? 1 : p);
    b[nb++] = 1'b0;
    for (int i = 0; i < 8; i++) b[nb++] = d[i];
    if (pm == 2'b01 || pm == 2'b10) b[nb++] = ^d ^ (pm == 2'b10);
    b[nb++] = 1'b1;
    if (st) b[nb++] = 1'b1;
    check($sformatf("%s len", nm), len, nb * bp);
    for (int k = 0; k < nb; k++) begin
      check($sformatf("%s bit%0d head", nm, k), int'(line[k*bp]), int'(b[k]));
      check($sformatf("%s bit%0d tail", nm, k), int'(line[k*bp+bp-1]), int'(b[k]));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst txd", int'(txd), 1);
    check("rst tready", int'(tready), 0);
    check("rst busy", int'(busy), 0);
    rst = 1'b0;
    #1;
    check("release tready before edge", int'(tready), 0);
    @(posedge clk); #1;
    check("release tready", int'(tready), 1);
    check("release busy", int'(busy), 0);
    repeat (20) @(posedge clk);
    #1;
    check("idle txd", int'(txd), 1);
    check("idle tready", int'(tready), 1);

    start_frame(8'h55, 16'd1, 2'b00, 1'b0, 1'b0);
    check("0x55 busy", int'(busy), 1);
    capture(n);
    check_frame("0x55", 8'h55, 1, 2'b00, 1'b0, n);

    start_frame(8'hA3, 16'd2, 2'b01, 1'b0, 1'b0);
    capture(n);
    check_frame("0xA3 even", 8'hA3, 2, 2'b01, 1'b0, n);
    check("0xA3 even parity", int'(line[9*16+8]), 0);

    start_frame(8'hA3, 16'd2, 2'b10, 1'b0, 1'b0);
    capture(n);
    check_frame("0xA3 odd", 8'hA3, 2, 2'b10, 1'b0, n);
    check("0xA3 odd parity", int'(line[9*16+8]), 1);

    start_frame(8'h3C, 16'd1, 2'b11, 1'b0, 1'b0);
    capture(n);
    check_frame("mode11 none", 8'h3C, 1, 2'b11, 1'b0, n);

    start_frame(8'hFF, 16'd0, 2'b00, 1'b0, 1'b0);
    capture(n);
    check_frame("p0 0xFF", 8'hFF, 0, 2'b00, 1'b0, n);

    start_frame(8'h01, 16'd1, 2'b00, 1'b1, 1'b1);
    tdata = 8'h80;
    capture(n);
    check_frame("btb 0x01", 8'h01, 1, 2'b00, 1'b1, n);
    check("btb idle txd", int'(txd), 1);
    run = 1;
    for (int k = n - 1; k >= 0 && line[k]; k--) run++;
    @(posedge clk); #1;
    tvalid = 1'b0;
    check("btb high run", run, 17);
    check("btb start2 txd", int'(txd), 0);
    check("btb start2 busy", int'(busy), 1);
    capture(n2);
    check_frame("btb 0x80", 8'h80, 1, 2'b00, 1'b1, n2);

    start_frame(8'h55, 16'd1, 2'b00, 1'b0, 1'b0);
    prescale = 16'd4;
    capture(n);
    check_frame("presc change cur", 8'h55, 1, 2'b00, 1'b0, n);
    start_frame(8'h0F, 16'd4, 2'b00, 1'b0, 1'b0);
    capture(n);
    check_frame("presc change next", 8'h0F, 4, 2'b00, 1'b0, n);

    start_frame(8'h55, 16'd1, 2'b00, 1'b0, 1'b0);
    repeat (35) @(posedge clk);
    #1;
    check("abort pre txd", int'(txd), 0);
    check("abort pre busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    check("abort txd", int'(txd), 1);
    check("abort busy", int'(busy), 0);
    check("abort tready", int'(tready), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort release tready", int'(tready), 1);
    start_frame(8'hA3, 16'd1, 2'b00, 1'b0, 1'b0);
    capture(n);
    check_frame("after abort", 8'hA3, 1, 2'b00, 1'b0, n);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
